// File: rtl/fifo_push_arbiter_pkg.sv
// fifo_push_arbiter_pkg: shared types for the packet-locking FIFO push arbiter.
package fifo_push_arbiter_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} arb_state_e;
endpackage

// File: rtl/fifo.sv
// fifo: synchronous single-clock FIFO; caller guards push against full and pop against empty.
module fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    always_comb begin
        wr_d = wr_q + {{AW{1'b0}}, push};
        rd_d = rd_q + {{AW{1'b0}}, pop};
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= push_data;
    end
    // The extra pointer bit tells a full wrap from empty.
    assign pop_data = mem_q[rd_q[AW-1:0]];
    assign empty    = wr_q == rd_q;
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
endmodule

// File: rtl/rr_pick.sv
// rr_pick: round-robin pick of the first requester after the last grant, wrapping.
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic [$clog2(NREQ)-1:0] next_id,
    output logic                    any
);
    localparam int GW = $clog2(NREQ);
    always_comb begin
        next_id = '0;
        any     = |req;
        // Scan from the farthest offset down so the nearest requester after last wins.
        for (int i = NREQ; i >= 1; i--) begin
            automatic logic [GW-1:0] c = GW'((int'(last) + i) % NREQ);
            if (req[c]) next_id = c;
        end
    end
endmodule

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin, packet-locking arbiter sharing one byte FIFO among NREQ producers.
module fifo_push_arbiter
    import fifo_push_arbiter_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ-1:0]              req_last,
    input  logic [NREQ*DATA_WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]              req_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(NREQ)-1:0]      grant_id,
    output logic                         busy,
    output logic [$clog2(DEPTH):0]       level
);
    localparam int GID_W = $clog2(NREQ);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    arb_state_e state_q, state_d;
    logic [GID_W-1:0] grant_q, grant_d, pick;
    logic [LVL_W-1:0] level_q, level_d;
    logic [DATA_WIDTH-1:0] push_data;
    logic pick_any, push, pop, full, empty;
    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req_valid),
        .last   (grant_q),
        .next_id(pick),
        .any    (pick_any)
    );
    fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .pop_data (out_data),
        .full     (full),
        .empty    (empty)
    );
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        req_ready = '0;
        push      = 1'b0;
        push_data = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
        if (state_q == ST_IDLE) begin
            if (pick_any) begin
                grant_d = pick;
                state_d = ST_LOCK;
            end
        end else begin
            // Ready follows registered full only, so a same-cycle pop never frees a slot.
            req_ready[grant_q] = !full;
            push = req_valid[grant_q] && !full;
            if (push && req_last[grant_q]) state_d = ST_IDLE;
        end
        pop     = !empty && out_ready;
        level_d = level_q + {{(LVL_W-1){1'b0}}, push} - {{(LVL_W-1){1'b0}}, pop};
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            grant_q <= GID_W'(NREQ - 1);
            level_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            level_q <= level_d;
        end
    end
    assign out_valid = !empty;
    assign grant_id  = grant_q;
    assign busy      = state_q == ST_LOCK;
    assign level     = level_q;
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: randomized producers against a queue-based reference; monitor scoreboards popped bytes.
module tb_fifo_push_arbiter;
    localparam int NREQ = 4, DW = 8, DEPTH = 16;
    logic clk = 1'b0, resetn = 1'b0, out_ready = 1'b0;
    logic [NREQ-1:0] req_valid = '0, req_last = '0, req_ready;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [DW-1:0] out_data;
    logic out_valid, busy;
    logic [$clog2(NREQ)-1:0] grant_id;
    logic [$clog2(DEPTH):0] level;

    fifo_push_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .grant_id(grant_id),
        .busy(busy), .level(level)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [DW:0] src_q [NREQ][$];
    logic [DW-1:0] exp_q [$];
    int m_lock = 0, m_gid = NREQ - 1, m_level = 0;
    int rdy_mode = 0, max_lvl = 0;

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add_pkt(int r, int len);
        for (int k = 0; k < len; k++)
            src_q[r].push_back({(k == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = src_q[i].size() > 0;
            {req_last[i], req_data[i*DW +: DW]} = req_valid[i] ? src_q[i][0] : '0;
        end
        out_ready = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
    endtask

    // Reference: owner is held from first beat to last; a free arbiter takes
    // the first valid requester after the previous owner, one cycle later.
    task automatic cycle();
        int push, pop, exp_rdy;
        logic [DW:0] b;
        drive();
        @(negedge clk);
        exp_rdy = (m_lock != 0 && m_level < DEPTH) ? (1 << m_gid) : 0;
        chk("req_ready", int'(req_ready), exp_rdy);
        chk("busy", int'(busy), m_lock);
        chk("grant_id", int'(grant_id), m_gid);
        chk("level", int'(level), m_level);
        chk("out_valid", int'(out_valid), int'(m_level > 0));
        if (int'(level) > max_lvl) max_lvl = int'(level);
        if (!resetn) begin
            m_lock = 0; m_gid = NREQ - 1; m_level = 0;
            exp_q.delete();
        end else begin
            b = '0;
            push = int'(m_lock != 0 && m_level < DEPTH && req_valid[m_gid]);
            pop = int'(m_level > 0 && out_ready);
            if (push != 0) begin
                b = src_q[m_gid].pop_front();
                exp_q.push_back(b[DW-1:0]);
            end
            m_level += push - pop;
            if (m_lock == 0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int c = (m_gid + k) % NREQ;
                    if (req_valid[c]) begin
                        m_gid = c; m_lock = 1;
                        break;
                    end
                end
            end else if (push != 0 && b[DW]) m_lock = 0;
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (resetn && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL out_data: popped %0h with nothing expected", out_data);
            end else chk("out_data", int'(out_data), int'(exp_q.pop_front()));
        end
    end

    initial begin
        int busy_src;
        repeat (2) @(posedge clk);
        #1;
        cycle();
        resetn = 1'b1;
        // Directed 3-byte packet on req0.
        rdy_mode = 1;
        src_q[0].push_back(9'h041); src_q[0].push_back(9'h042); src_q[0].push_back(9'h143);
        repeat (8) cycle();
        // Everyone streaming single-beat packets.
        for (int n = 0; n < 3; n++) for (int r = 0; r < NREQ; r++) add_pkt(r, 1);
        repeat (30) cycle();
        // req1 two-beat packet, req2 arrives mid-packet.
        add_pkt(1, 2);
        repeat (2) cycle();
        add_pkt(2, 2);
        repeat (10) cycle();
        // Fill past capacity with the consumer stalled, then drain.
        rdy_mode = 0; max_lvl = 0;
        add_pkt(0, 20);
        repeat (25) cycle();
        chk("peak level", max_lvl, DEPTH);
        rdy_mode = 1;
        repeat (30) cycle();
        chk("level after drain", int'(level), 0);
        // Reset mid-packet at level 5.
        rdy_mode = 0;
        add_pkt(2, 8);
        for (int n = 0; n < 40 && m_level != 5; n++) cycle();
        chk("level before reset", int'(level), 5);
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        for (int r = 0; r < NREQ; r++) src_q[r].delete();
        for (int r = NREQ - 1; r >= 0; r--) add_pkt(r, 1);
        rdy_mode = 1;
        cycle();
        chk("first grant after reset", int'(grant_id), 0);
        repeat (12) cycle();
        // Random traffic.
        rdy_mode = 2;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                int r = $urandom_range(0, NREQ - 1);
                if (src_q[r].size() < 12) add_pkt(r, $urandom_range(1, 5));
            end
            cycle();
        end
        rdy_mode = 1;
        for (int n = 0; n < 400; n++) begin
            busy_src = 0;
            for (int r = 0; r < NREQ; r++) busy_src += src_q[r].size();
            if (busy_src == 0 && exp_q.size() == 0 && m_lock == 0) break;
            cycle();
        end
        chk("final level", int'(level), 0);
        chk("scoreboard drained", exp_q.size(), 0);
        chk("producers drained", busy_src, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
